// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - arbitrates icache and LSB requests onto the byte-serial memory controller
module mem_req_arbiter #(
  parameter int          ADDR_W       = 32,
  parameter int          STARVE_LIMIT = 8,
  parameter logic [1:0]  IO_PREFIX    = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              io_buffer_full,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_done,
  output logic [31:0]       ic_instr,
  input  logic              lsb_req,
  input  logic              lsb_wr,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [2:0]        lsb_len,
  input  logic              lsb_signed,
  input  logic [31:0]       lsb_wdata,
  output logic              lsb_done,
  output logic [31:0]       lsb_rdata,
  output logic              mc_start,
  output logic              mc_wr,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [2:0]        mc_len,
  output logic [31:0]       mc_wdata,
  input  logic              mc_done,
  input  logic [31:0]       mc_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t           state, state_nx;
  logic             owner_lsb;
  logic             sign_q;
  logic [CNT_W-1:0] starve_cnt;

  logic ic_elig, lsb_elig, io_block, starved;
  logic grant_ic, grant_lsb, committed, finish, ic_wait;

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] len,
                                         input logic sgn);
    logic [31:0] r;
    case (len)
      3'd1:    r = {{24{sgn & d[7]}}, d[7:0]};
      3'd2:    r = {{16{sgn & d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    io_block  = lsb_wr && (lsb_addr[17:16] == IO_PREFIX) && io_buffer_full;
    // a requester whose done is high this cycle is still holding its old req
    ic_elig   = ic_req && !ic_done && !flush;
    lsb_elig  = lsb_req && !lsb_done && !flush && !io_block;
    starved   = starve_cnt >= CNT_W'(STARVE_LIMIT);
    grant_lsb = (state == IDLE) && lsb_elig && !(ic_elig && starved);
    grant_ic  = (state == IDLE) && ic_elig && !grant_lsb;
    committed = owner_lsb && mc_wr;
    ic_wait   = ic_req && !((state != IDLE) && !owner_lsb) && !grant_ic;

    state_nx = state;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (grant_lsb || grant_ic) state_nx = BUSY;
      end
      BUSY: begin
        // committed stores must complete and report even across a mispredict
        if (flush && !committed) begin
          state_nx = mc_done ? IDLE : DRAIN;
        end else if (mc_done) begin
          state_nx = IDLE;
          finish   = 1'b1;
        end
      end
      DRAIN: begin
        if (mc_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner_lsb  <= 1'b0;
      sign_q     <= 1'b0;
      starve_cnt <= '0;
      ic_done    <= 1'b0;
      ic_instr   <= '0;
      lsb_done   <= 1'b0;
      lsb_rdata  <= '0;
      mc_start   <= 1'b0;
      mc_wr      <= 1'b0;
      mc_addr    <= '0;
      mc_len     <= '0;
      mc_wdata   <= '0;
    end else if (rdy) begin
      state    <= state_nx;
      mc_start <= grant_lsb || grant_ic;
      ic_done  <= finish && !owner_lsb;
      lsb_done <= finish && owner_lsb;

      if (grant_lsb) begin
        owner_lsb <= 1'b1;
        mc_wr     <= lsb_wr;
        mc_addr   <= lsb_addr;
        mc_len    <= lsb_len;
        mc_wdata  <= lsb_wdata;
        sign_q    <= lsb_signed;
      end else if (grant_ic) begin
        owner_lsb <= 1'b0;
        mc_wr     <= 1'b0;
        mc_addr   <= ic_addr;
        mc_len    <= 3'd4;
        mc_wdata  <= '0;
        sign_q    <= 1'b0;
      end

      if (finish && !owner_lsb) ic_instr <= mc_rdata;
      if (finish && owner_lsb && !mc_wr) lsb_rdata <= extend(mc_rdata, mc_len, sign_q);

      if (!ic_req || grant_ic) begin
        starve_cnt <= '0;
      end else if (ic_wait && !starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Sits between the two memory requesters (instruction cache, load/store buffer) and the byte-serial memory controller.
- Picks one request at a time and latches its address, length, direction and write data. Issues a single-cycle start to the memory controller, waits for its completion, then routes the result back as a one-cycle done pulse.
- Handles branch-mispredict flush without corrupting in-flight committed stores.
- Stalls I/O stores while the I/O buffer is full, and prevents instruction-fetch starvation.

Parameters:
- ADDR_W, 32, address width
- STARVE_LIMIT, 8, consecutive cycles icache may wait while pending before it gets priority over LSB
- IO_PREFIX, 2'b11, value of addr[17:16] that marks an I/O access

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; when low all registers hold
- flush  in  1  ROB mispredict (jump_wrong)
- io_buffer_full  in  1  I/O output buffer full
- ic_req  in  1  icache read request (level, held until ic_done)
- ic_addr  in  ADDR_W  fetch address
- ic_done  out  1  one-cycle pulse: instruction valid
- ic_instr  out  32  fetched word
- lsb_req  in  1  LSB request (level, held until lsb_done)
- lsb_wr  in  1  1=store, 0=load
- lsb_addr  in  ADDR_W  access address
- lsb_len  in  3  byte count: 1, 2 or 4
- lsb_signed  in  1  load sign-extend enable
- lsb_wdata  in  32  store data, little-endian low bytes
- lsb_done  out  1  one-cycle pulse: access complete
- lsb_rdata  out  32  extended load data
- mc_start  out  1  one-cycle start pulse to memory controller
- mc_wr  out  1  latched direction
- mc_addr  out  ADDR_W  latched address
- mc_len  out  3  latched byte count (4 for icache)
- mc_wdata  out  32  latched store data
- mc_done  in  1  one-cycle completion from memory controller
- mc_rdata  in  32  raw read data, zero above len bytes

Behaviour:
- Reset values:
  - state=IDLE, starve_cnt=0.
  - All done/start pulses 0; ic_instr, lsb_rdata, mc_* = 0.
- rdy low:
  - No register changes, including the pulse outputs (the memory controller also freezes).
- States: IDLE, BUSY, DRAIN. The granted owner is latched as owner ∈ {IC, LSB}.
- IDLE:
  - A requester is eligible when its req=1, its own done output is not high this cycle, and flush=0.
  - LSB is additionally ineligible when lsb_wr=1, lsb_addr[17:16]==IO_PREFIX and io_buffer_full=1. In that case icache may be granted instead.
  - Priority goes to LSB, unless both are eligible and starve_cnt >= STARVE_LIMIT; then IC wins.
  - On grant: latch the mc_* fields and owner, drive mc_start=1 for the next cycle only, and move to BUSY.
  - No eligible requester: stay in IDLE, mc_start=0.
- BUSY, no flush this cycle:
  - On mc_done: go to IDLE.
  - Next cycle, the owner's done pulses high with its data.
  - Earliest re-grant is the cycle in which that done is high. The finished requester is masked that cycle; the other requester may be granted.
- BUSY with flush:
  - If owner=LSB and mc_wr=1, the store is committed. Continue exactly as without flush; lsb_done still pulses.
  - Otherwise (any read) go to DRAIN. If mc_done arrives in the flush cycle itself, go straight to IDLE with no done pulse.
- DRAIN:
  - Wait for mc_done, then go to IDLE.
  - The result is discarded: no done pulse, outputs unchanged. Further flushes are ignored.
- Load extension, registered into lsb_rdata:
  - len=1: bit 7 replicated into [31:8] if lsb_signed, else zero.
  - len=2: bit 15 replicated into [31:16] if lsb_signed, else zero.
  - len=4: passed through unchanged.
  - Stores leave lsb_rdata unchanged.
- ic_instr = mc_rdata on the IC done cycle.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, every rdy cycle in which ic_req=1 and IC is neither owner-in-flight nor granted.
  - Clears on IC grant, and on any cycle with ic_req=0.
- Illegal lsb_len values (0, 3, 5–7) are forwarded unchanged to mc_len. Extension then treats them as len=4.
- Reset mid-operation: returns to IDLE immediately, with no done pulse. The memory controller is reset by the same rst.

Test Plan:
- Simultaneous ic_req (addr 0x100) and LSB load (addr 0x200, len 4) from IDLE, no starvation → LSB granted: mc_start pulses one cycle later with mc_addr=0x200, mc_len=4. After mc_done with rdata 0x12345678, lsb_done=1 and lsb_rdata=0x12345678. IC is granted in that same cycle.
- Signed byte load, rdata 0x00000080 → lsb_rdata=0xFFFFFF80. Unsigned halfword load, rdata 0x0000F00F → lsb_rdata=0x0000F00F. Signed halfword of the same value → 0xFFFFF00F.
- IC read in BUSY, flush asserted, mc_done 3 cycles later → state goes to DRAIN, ic_done never pulses, ic_instr unchanged, next grant occurs after IDLE is reached.
- LSB store (addr 0x300, wdata 0xAABBCCDD, len 4) in BUSY, flush asserted → lsb_done still pulses after mc_done; mc_wr=1 throughout.
- LSB store to 0x30000 with io_buffer_full=1 and ic_req=1 → IC granted. Store issues only once io_buffer_full=0 and the arbiter is back in IDLE.
- LSB requests back-to-back continuously with ic_req held → IC granted no later than after STARVE_LIMIT waiting cycles once in IDLE; starve_cnt returns to 0.
